// File: rtl/aes_const_pack.sv
// aes_const_pack
//   AES-128 constants: number of rounds, the round-constant table, the S-box
//   and the SubWord helper used by the key expansion.
package aes_const_pack;

  localparam int NUM_ROUNDS = 10;

  // Indexed by round number 1..10; entry 0 and the tail are padding so any
  // 4-bit index stays inside the table.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_model_pack.sv
// aes_model_pack
//   Shared data-layout definitions for the AES datapath.
//   byte_table is the 128-bit AES state, indexed [row][col]. It is stored
//   row-major with state[0][0] in the top byte: byte (r,c) lives at
//   bits [127 - 8*(4*r + c) -: 8]. The helpers below are the only place that
//   knows this layout, so the rest of the datapath never hand-computes offsets.
package aes_model_pack;

  typedef logic [127:0] byte_table;

  function automatic logic [7:0] get_byte(input byte_table t, input int r, input int c);
    return t[127 - 8*(4*r + c) -: 8];
  endfunction

  // A FIPS byte stream fills the state column by column: byte n goes to
  // state[n%4][n/4]. This is effectively a transpose into row-major form.
  function automatic byte_table stream_to_table(input logic [127:0] s);
    byte_table t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127 - 8*(4*r + c) -: 8] = s[127 - 8*(4*c + r) -: 8];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/add_round_key_stage_if.sv
// add_round_key_stage_if
//   Key-load, input-state and output-state channels of the AddRoundKey stage.
//   slave  : the stage itself (consumes key/in_*, produces out_*, in_ready).
//   master : the upstream/downstream environment driving the stage.
//   Signals:
//     key_load, key_in[127:0]   cipher key load (FIPS byte stream)
//     in_valid, in_ready, in_block[127:0]          input state handshake
//     out_valid, out_ready, out_block[127:0],
//     out_round[3:0], out_last                      output state handshake
interface add_round_key_stage_if;
  import aes_model_pack::*;

  logic          key_load;
  logic [127:0]  key_in;
  logic          in_valid;
  logic          in_ready;
  byte_table     in_block;
  logic          out_valid;
  logic          out_ready;
  byte_table     out_block;
  logic [3:0]    out_round;
  logic          out_last;

  modport master (
    output key_load, key_in, in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block, out_round, out_last
  );

  modport slave (
    input  key_load, key_in, in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block, out_round, out_last
  );

endinterface

// File: rtl/aes_key_step.sv
// aes_key_step
//   Purely combinational single round of the AES-128 key schedule.
//   Ports:
//     rk[127:0]       current round key, byte_table form
//     rcon[7:0]       round constant for the round being produced
//     next_rk[127:0]  following round key, byte_table form
//   Each key word is one state column, so the columns are gathered into
//   words, run through the FIPS-197 recurrence and scattered back.
module aes_key_step
  import aes_model_pack::*;
  import aes_const_pack::*;
(
  input  byte_table   rk,
  input  logic [7:0]  rcon,
  output byte_table   next_rk
);

  logic [31:0] w  [4];
  logic [31:0] nw [4];
  logic [31:0] rot;

  // Column c of the state is key word c, row 0 being the word's top byte.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w[c] = {get_byte(rk, 0, c), get_byte(rk, 1, c), get_byte(rk, 2, c), get_byte(rk, 3, c)};
    end
  end

  // Four S-box lookups, all in this one combinational step.
  always_comb begin
    rot   = {w[3][23:0], w[3][31:24]};
    nw[0] = w[0] ^ sub_word(rot) ^ {rcon, 24'h000000};
    nw[1] = w[1] ^ nw[0];
    nw[2] = w[2] ^ nw[1];
    nw[3] = w[3] ^ nw[2];
  end

  always_comb begin
    next_rk = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        next_rk[127 - 8*(4*r + c) -: 8] = nw[c][31 - 8*r -: 8];
      end
    end
  end

endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage
//   AddRoundKey stage of the iterative AES-128 datapath, directly upstream of
//   sub_bytes. Each accepted state is XORed with the current round key and
//   registered; the key schedule advances one round per accepted block and
//   wraps back to the cipher key after the last round.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     bus (slave)       key load, input and output handshakes
//   Optional build macro ARK_DEBUG_PORTS_EN adds:
//     dbg_round_key[127:0]  current round key (byte_table form)
//     dbg_round[3:0]        current round counter
module add_round_key_stage
  import aes_model_pack::*;
#(
  parameter int NUM_ROUNDS = aes_const_pack::NUM_ROUNDS
) (
  input logic clk,
  input logic rst,
  add_round_key_stage_if.slave bus
`ifdef ARK_DEBUG_PORTS_EN
  ,
  output logic [127:0] dbg_round_key,
  output logic [3:0]   dbg_round
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  byte_table  cipher_key;
  byte_table  rk;
  byte_table  next_rk;
  logic [3:0] round;
  logic       key_ok;
  logic [7:0] rcon_sel;
  logic       in_ready;
  logic       accept;
  logic       out_valid;
  byte_table  out_block;
  logic [3:0] out_round;
  logic       out_last;

  // A key load blocks acceptance in its own cycle so the schedule restart
  // never races a block using the old key.
  assign in_ready = key_ok & ~bus.key_load & (~out_valid | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign rcon_sel = aes_const_pack::RCON[round + 4'd1];

  aes_key_step u_key_step (
    .rk      (rk),
    .rcon    (rcon_sel),
    .next_rk (next_rk)
  );

  // Output register plus key schedule state. The output register is left
  // alone by key_load, so a pending block drains with its original key.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_block  <= '0;
      out_round  <= 4'd0;
      out_last   <= 1'b0;
      key_ok     <= 1'b0;
      round      <= 4'd0;
      cipher_key <= '0;
      rk         <= '0;
    end else begin
      if (accept) begin
        out_block <= bus.in_block ^ rk;
        out_round <= round;
        out_last  <= (round == LAST_ROUND);
        out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end

      if (bus.key_load) begin
        cipher_key <= stream_to_table(bus.key_in);
        rk         <= stream_to_table(bus.key_in);
        round      <= 4'd0;
        key_ok     <= 1'b1;
      end else if (accept) begin
        if (round < LAST_ROUND) begin
          rk    <= next_rk;
          round <= round + 4'd1;
        end else begin
          rk    <= cipher_key;
          round <= 4'd0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_block = out_block;
  assign bus.out_round = out_round;
  assign bus.out_last  = out_last;

`ifdef ARK_DEBUG_PORTS_EN
  // rk and round are already registers that clear on reset.
  assign dbg_round_key = rk;
  assign dbg_round     = round;
`endif

endmodule
